// File: rtl/booth_pair_multiplier_pkg.sv
// Shared definitions for the radix-4 Booth multiplier slice.
// Contents:
//   ST_IDLE/ST_RUN/ST_DONE - FSM state encoding
//   booth_sel_t, SEL_*     - partial-product select codes from the recoder
//   iter_count()           - number of recoded pairs for a given operand width
package booth_pair_multiplier_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef logic [2:0] booth_sel_t;

  localparam booth_sel_t SEL_ZERO = 3'd0;
  localparam booth_sel_t SEL_PM   = 3'd1;
  localparam booth_sel_t SEL_P2M  = 3'd2;
  localparam booth_sel_t SEL_NM   = 3'd3;
  localparam booth_sel_t SEL_N2M  = 3'd4;

  // One recoded bit pair is consumed per iteration.
  function automatic int iter_count(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/booth_pair_multiplier_if.sv
// Operand/result bundle between the bus side and the Booth multiplier.
// Signals:
//   start                    request, operands sampled on the accepting edge
//   multiplicand, multiplier signed operands M and Q
//   busy                     high while iterating
//   done                     one-cycle pulse when z_hi/z_lo hold a new product
//   z_hi, z_lo               registered product halves (feed ZHI/ZLO)
// Modports: master drives requests, slave is the multiplier.
interface booth_pair_multiplier_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  start;
  logic [DATA_WIDTH-1:0] multiplicand;
  logic [DATA_WIDTH-1:0] multiplier;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] z_hi;
  logic [DATA_WIDTH-1:0] z_lo;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, z_hi, z_lo
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, z_hi, z_lo
  );

endinterface

// File: rtl/booth_pair_multiplier_recoder.sv
// Combinational radix-4 Booth recoder.
// Ports:
//   triplet  in   {Q[2i+1], Q[2i], Q[2i-1]}
//   sel      out  partial-product select code (0, +M, +2M, -M, -2M)
module booth_pair_multiplier_recoder
  import booth_pair_multiplier_pkg::*;
(
  input  logic [2:0] triplet,
  output booth_sel_t sel
);

  // Standard bit-pair table: value = -2*q1 + q0 + q_minus1.
  always_comb begin
    sel = SEL_ZERO;
    case (triplet)
      3'b000:  sel = SEL_ZERO;
      3'b001:  sel = SEL_PM;
      3'b010:  sel = SEL_PM;
      3'b011:  sel = SEL_P2M;
      3'b100:  sel = SEL_N2M;
      3'b101:  sel = SEL_NM;
      3'b110:  sel = SEL_NM;
      3'b111:  sel = SEL_ZERO;
      default: sel = SEL_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_pair_multiplier.sv
// Sequential signed multiplier using radix-4 Booth recoding, one bit pair
// per clock. The product goes straight to the ZHI/ZLO register pair: z_hi/z_lo
// feed their D inputs and done drives their enable.
// Ports:
//   clock  in   single clock, posedge
//   clear  in   synchronous active-high reset; aborts any operation
//   bus    slave modport of booth_pair_multiplier_if (start, operands,
//          busy, done, z_hi, z_lo)
module booth_pair_multiplier
  import booth_pair_multiplier_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    clear,
  booth_pair_multiplier_if.slave  bus
);

  localparam int N  = iter_count(DATA_WIDTH);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * DATA_WIDTH;

  logic [1:0]            state;
  logic [PW-1:0]         m_ext;
  logic [DATA_WIDTH:0]   q_ext;
  logic [PW-1:0]         acc;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] z_hi_q;
  logic [DATA_WIDTH-1:0] z_lo_q;

  logic [2:0]            triplet;
  booth_sel_t            sel;
  logic [PW-1:0]         addend;
  logic [PW-1:0]         acc_next;
  logic                  last_iter;

  // q_ext carries Q with the implicit Q[-1]=0 appended at bit 0, so pair i
  // occupies q_ext[2i+2:2i].
  assign triplet   = 3'(q_ext >> {count, 1'b0});
  assign last_iter = (count == CW'(N - 1));

  booth_pair_multiplier_recoder u_recoder (
    .triplet (triplet),
    .sel     (sel)
  );

  // Partial product chosen by the recoder, before weighting by 4^i.
  always_comb begin
    addend = '0;
    case (sel)
      SEL_PM:  addend = m_ext;
      SEL_P2M: addend = m_ext << 1;
      SEL_NM:  addend = ~m_ext + PW'(1);
      SEL_N2M: addend = ~(m_ext << 1) + PW'(1);
      default: addend = '0;
    endcase
  end

  // Weight 4^i is a shift by 2i; carries out of the top bit are dropped.
  assign acc_next = acc + (addend << {count, 1'b0});

  // FSM, operand latches, accumulator and output registers. The product
  // registers only move on the completion edge or on clear, so ZHI/ZLO
  // always see the last finished product.
  always_ff @(posedge clock) begin
    if (clear) begin
      state  <= ST_IDLE;
      m_ext  <= '0;
      q_ext  <= '0;
      acc    <= '0;
      count  <= '0;
      z_hi_q <= '0;
      z_lo_q <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            m_ext <= {{DATA_WIDTH{bus.multiplicand[DATA_WIDTH-1]}}, bus.multiplicand};
            q_ext <= {bus.multiplier, 1'b0};
            acc   <= '0;
            count <= '0;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc   <= acc_next;
          count <= count + CW'(1);
          if (last_iter) begin
            z_hi_q <= acc_next[PW-1:DATA_WIDTH];
            z_lo_q <= acc_next[DATA_WIDTH-1:0];
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state == ST_RUN);
  assign bus.done = (state == ST_DONE);
  assign bus.z_hi = z_hi_q;
  assign bus.z_lo = z_lo_q;

endmodule

// File: tb/tb_booth_pair_multiplier.sv
// Self-checking bench for booth_pair_multiplier (DATA_WIDTH=32).
// A transaction-level model (product by plain signed multiply, completion
// after a fixed iteration delay) is compared against every output on every
// negedge; directed scenarios add literal expectations on top.
module tb_booth_pair_multiplier;

  localparam int DW = 32;
  localparam int N  = DW / 2;

  logic clock = 1'b0;
  logic clear;

  booth_pair_multiplier_if #(.DATA_WIDTH(DW)) bus ();

  booth_pair_multiplier #(.DATA_WIDTH(DW)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit compare_on = 1'b0;

  // Reference model state
  int                run_left = 0;
  logic              exp_busy = 1'b0;
  logic              exp_done = 1'b0;
  logic [DW-1:0]     exp_hi   = '0;
  logic [DW-1:0]     exp_lo   = '0;
  logic [2*DW-1:0]   pend     = '0;

  function automatic logic [2*DW-1:0] ref_product(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: an accepted request completes N edges later with the exact
  // product; requests while a product is in flight are ignored.
  always @(posedge clock) begin
    if (clear) begin
      run_left = 0;
      exp_done = 1'b0;
      exp_hi   = '0;
      exp_lo   = '0;
    end else if (run_left > 0) begin
      run_left--;
      if (run_left == 0) begin
        exp_hi   = pend[2*DW-1:DW];
        exp_lo   = pend[DW-1:0];
        exp_done = 1'b1;
      end
    end else begin
      exp_done = 1'b0;
      if (bus.start) begin
        pend     = ref_product(bus.multiplicand, bus.multiplier);
        run_left = N;
      end
    end
    exp_busy = (run_left > 0);
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clock) begin
    if (compare_on) begin
      check_output("busy", 64'(bus.busy), 64'(exp_busy));
      check_output("done", 64'(bus.done), 64'(exp_done));
      check_output("z_hi", 64'(bus.z_hi), 64'(exp_hi));
      check_output("z_lo", 64'(bus.z_lo), 64'(exp_lo));
    end
  end

  task automatic apply_stimulus(input logic [DW-1:0] m, input logic [DW-1:0] q);
    @(posedge clock);
    #2;
    bus.start        = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    @(posedge clock);
    #2;
    bus.start        = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
  endtask

  task automatic wait_done(input int limit, output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      cycles++;
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.done === 1'b1) return;
    end
    n_checks++;
    n_fail++;
    $display("[TB] FAIL done_timeout: got no done in %0d cycles, expected one", limit);
  endtask

  task automatic count_dones(input int window, output int dones);
    dones = 0;
    for (int i = 0; i < window; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1) dones++;
    end
  endtask

  initial begin
    int cyc;
    int bcyc;
    int dones;
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;

    // Watchdog keeps the run bounded whatever the DUT does.
    fork
      begin
        #2000000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
      end
    join_none

    clear            = 1'b1;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    // Pin the model with hand-computed products.
    check_output("model_7xm3", ref_product(32'd7, 32'hFFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
    check_output("model_min",  ref_product(32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);
    check_output("model_max",  ref_product(32'h7FFF_FFFF, 32'h7FFF_FFFF), 64'h3FFF_FFFF_0000_0001);

    @(posedge clock);
    compare_on = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    clear = 1'b0;

    @(negedge clock);
    check_output("reset_busy", 64'(bus.busy), 64'd0);
    check_output("reset_done", 64'(bus.done), 64'd0);
    check_output("reset_z",    {bus.z_hi, bus.z_lo}, 64'd0);

    // 7 x -3: latency and busy length
    apply_stimulus(32'd7, 32'hFFFF_FFFD);
    wait_done(40, cyc, bcyc);
    check_output("lat_7xm3",  64'(cyc), 64'd17);
    check_output("busy_7xm3", 64'(bcyc), 64'd16);
    check_output("zhi_7xm3",  64'(bus.z_hi), 64'hFFFF_FFFF);
    check_output("zlo_7xm3",  64'(bus.z_lo), 64'hFFFF_FFEB);

    // Most-negative and most-positive operands
    apply_stimulus(32'h8000_0000, 32'h8000_0000);
    wait_done(40, cyc, bcyc);
    check_output("zhi_min", 64'(bus.z_hi), 64'h4000_0000);
    check_output("zlo_min", 64'(bus.z_lo), 64'h0000_0000);
    apply_stimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_done(40, cyc, bcyc);
    check_output("zhi_max", 64'(bus.z_hi), 64'h3FFF_FFFF);
    check_output("zlo_max", 64'(bus.z_lo), 64'h0000_0001);

    // -1 x -1 with start re-asserted mid-run
    apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (4) @(posedge clock);
    #2;
    bus.start        = 1'b1;
    bus.multiplicand = 32'd3;
    bus.multiplier   = 32'd4;
    repeat (2) @(posedge clock);
    #2;
    bus.start = 1'b0;
    wait_done(40, cyc, bcyc);
    check_output("zhi_m1", 64'(bus.z_hi), 64'd0);
    check_output("zlo_m1", 64'(bus.z_lo), 64'd1);
    count_dones(25, dones);
    check_output("extra_done_m1", 64'(dones), 64'd0);

    // Back-to-back: 9 x 11 then 5 x 6 queued through DONE
    apply_stimulus(32'd9, 32'd11);
    repeat (8) @(posedge clock);
    #2;
    bus.start        = 1'b1;
    bus.multiplicand = 32'd5;
    bus.multiplier   = 32'd6;
    wait_done(40, cyc, bcyc);
    check_output("zlo_b2b_first", 64'(bus.z_lo), 64'd99);
    @(posedge clock);
    #2;
    bus.start        = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
    wait_done(40, cyc, bcyc);
    check_output("lat_b2b",     64'(cyc), 64'd17);
    check_output("zlo_b2b_2nd", 64'(bus.z_lo), 64'd30);
    check_output("zhi_b2b_2nd", 64'(bus.z_hi), 64'd0);

    // Abort with clear during run
    apply_stimulus(32'd123, 32'd456);
    repeat (7) @(posedge clock);
    #2;
    clear = 1'b1;
    @(posedge clock);
    #2;
    clear = 1'b0;
    @(negedge clock);
    check_output("abort_busy", 64'(bus.busy), 64'd0);
    check_output("abort_done", 64'(bus.done), 64'd0);
    check_output("abort_z",    {bus.z_hi, bus.z_lo}, 64'd0);
    count_dones(30, dones);
    check_output("abort_no_done", 64'(dones), 64'd0);
    apply_stimulus(32'd123, 32'd456);
    wait_done(40, cyc, bcyc);
    check_output("zlo_after_abort", 64'(bus.z_lo), 64'd56088);

    // Hold: product stays put with idle changing operands
    apply_stimulus(32'd4, 32'd5);
    wait_done(40, cyc, bcyc);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #2;
      bus.multiplicand = $urandom;
      bus.multiplier   = $urandom;
      @(negedge clock);
      if (bus.done === 1'b1) dones++;
    end
    check_output("hold_done", 64'(dones), 64'd0);
    check_output("hold_zlo",  64'(bus.z_lo), 64'd20);

    // Randomized operands, some runs aborted by clear
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'd0;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'h8000_0000;
        1:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      apply_stimulus(ra, rb);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 14)) @(posedge clock);
        #2;
        clear = 1'b1;
        @(posedge clock);
        #2;
        clear = 1'b0;
      end else begin
        wait_done(40, cyc, bcyc);
        check_output("rand_lat", 64'(cyc), 64'd17);
      end
      repeat ($urandom_range(0, 3)) @(posedge clock);
    end

    repeat (3) @(posedge clock);
    compare_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
